// File: rtl/hrange_arb_pkg.sv
// Shared types and defaults for the hrange arbiter.
// State encoding plus default sizing.
package hrange_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        STREAM
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N_REQ = 2;

endpackage

// File: rtl/hrange_arbiter_picker.sv
// Combinational round-robin picker.
// First set request at or after the pointer, with wrap.
module rr_picker #(
    parameter int N_REQ = 2,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    idx,
    output logic             found
);

    // scan from ptr upward, wrapping, keep the first hit
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/hrange_arbiter.sv
// Round-robin sharing of one hrange generator between requesters.
// Launches a run, forwards the stream to the owner, pulses its done.
module hrange_arbiter
    import hrange_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                   _clock,
    input  logic                   _reset,
    input  logic [N_REQ-1:0]       req_start,
    input  logic [N_REQ*WIDTH-1:0] req_base,
    input  logic [N_REQ*WIDTH-1:0] req_limit,
    input  logic [N_REQ*WIDTH-1:0] req_step,
    input  logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_done,
    output logic [N_REQ-1:0]       req_grant,
    output logic [WIDTH-1:0]       req__0,
    output logic                   gen__start,
    output logic                   gen__reset,
    output logic                   gen__ready,
    output logic [WIDTH-1:0]       gen_base,
    output logic [WIDTH-1:0]       gen_limit,
    output logic [WIDTH-1:0]       gen_step,
    input  logic                   gen__valid,
    input  logic                   gen__done,
    input  logic [WIDTH-1:0]       gen__0
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gidx;
    logic [N_REQ-1:0] pick_oh;
    logic [PW-1:0]    pick_idx;
    logic             pick_found;

    rr_picker #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req   (req_start),
        .ptr   (ptr),
        .grant (pick_oh),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign gen__reset = _reset;
    assign req__0     = gen__0;

    // ownership FSM: grant, launch, wait for end of run
    always_ff @(posedge _clock) begin
        if (_reset) begin
            state      <= IDLE;
            ptr        <= '0;
            gidx       <= '0;
            req_grant  <= '0;
            req_done   <= '0;
            gen__start <= 1'b0;
            gen_base   <= '0;
            gen_limit  <= '0;
            gen_step   <= '0;
        end else begin
            req_done <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        req_grant  <= pick_oh;
                        gidx       <= pick_idx;
                        gen_base   <= req_base[pick_idx*WIDTH +: WIDTH];
                        gen_limit  <= req_limit[pick_idx*WIDTH +: WIDTH];
                        gen_step   <= req_step[pick_idx*WIDTH +: WIDTH];
                        gen__start <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    // generator still shows its idle done here
                    gen__start <= 1'b0;
                    state      <= STREAM;
                end
                STREAM: begin
                    if (gen__done) begin
                        req_done  <= req_grant;
                        req_grant <= '0;
                        ptr       <= (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // zero-latency stream forwarding to the owner only
    always_comb begin
        req_valid  = '0;
        gen__ready = 1'b0;
        if (state == STREAM) begin
            req_valid[gidx] = gen__valid;
            gen__ready      = req_ready[gidx];
        end
    end

endmodule

// File: tb/tb_hrange_arbiter.sv
// Directed bench for hrange_arbiter with a behavioural hrange model.
// Inputs driven #1 after posedge; transfers logged on negedge.
module tb_hrange_arbiter;

    localparam int N = 2;
    localparam int W = 32;

    logic               clk;
    logic               rst;
    logic [N-1:0]       start;
    logic [W-1:0]       b [N];
    logic [W-1:0]       l [N];
    logic [W-1:0]       s [N];
    logic [N*W-1:0]     req_base;
    logic [N*W-1:0]     req_limit;
    logic [N*W-1:0]     req_step;
    logic [N-1:0]       ready;
    logic [N-1:0]       valid;
    logic [N-1:0]       done;
    logic [N-1:0]       grant;
    logic [W-1:0]       data;
    logic               gen_start;
    logic               gen_rst;
    logic               gen_ready;
    logic [W-1:0]       gen_base;
    logic [W-1:0]       gen_limit;
    logic [W-1:0]       gen_step;
    logic               gen_valid;
    logic               gen_done;
    logic [W-1:0]       gen_data;

    int total = 0;
    int bad   = 0;

    assign req_base  = {b[1], b[0]};
    assign req_limit = {l[1], l[0]};
    assign req_step  = {s[1], s[0]};

    hrange_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        ._clock     (clk),
        ._reset     (rst),
        .req_start  (start),
        .req_base   (req_base),
        .req_limit  (req_limit),
        .req_step   (req_step),
        .req_ready  (ready),
        .req_valid  (valid),
        .req_done   (done),
        .req_grant  (grant),
        .req__0     (data),
        .gen__start (gen_start),
        .gen__reset (gen_rst),
        .gen__ready (gen_ready),
        .gen_base   (gen_base),
        .gen_limit  (gen_limit),
        .gen_step   (gen_step),
        .gen__valid (gen_valid),
        .gen__done  (gen_done),
        .gen__0     (gen_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // hrange model: idle holds done, done rises after last transfer
    logic                m_run;
    logic signed [W-1:0] m_cur;
    logic signed [W-1:0] m_lim;
    logic signed [W-1:0] m_stp;

    assign gen_valid = m_run && (m_cur < m_lim);
    assign gen_done  = !m_run;
    assign gen_data  = m_cur;

    always @(posedge clk) begin
        if (gen_rst) begin
            m_run <= 1'b0;
            m_cur <= '0;
            m_lim <= '0;
            m_stp <= '0;
        end else if (gen_start) begin
            m_run <= 1'b1;
            m_cur <= gen_base;
            m_lim <= gen_limit;
            m_stp <= gen_step;
        end else if (m_run) begin
            if (gen_valid && gen_ready)
                m_cur <= m_cur + m_stp;
            else if (!gen_valid)
                m_run <= 1'b0;
        end
    end

    int q0[$];
    int q1[$];
    int vhi1    = 0;
    int overlap = 0;
    int stray   = 0;

    always @(negedge clk) begin
        if (valid[0] && ready[0]) q0.push_back(int'(data));
        if (valid[1] && ready[1]) q1.push_back(int'(data));
        if (valid[1]) vhi1++;
        if (gen_done && gen_valid) overlap++;
        if ((valid & ~grant) != '0) stray++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int i, input int lim,
                             output int n);
        bit seen;
        seen = 0;
        n    = 0;
        while (!seen && n < lim) begin
            step();
            n++;
            if (done[i]) seen = 1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic chk_seq(input string tag, input int i, input int e[$]);
        int got[$];
        got = (i == 0) ? q0 : q1;
        chk({tag, "_len"}, 32'(got.size()), 32'(e.size()));
        for (int k = 0; k < e.size() && k < got.size(); k++)
            chk(tag, 32'(got[k]), 32'(e[k]));
    endtask

    task automatic set_req(input int i, input int bb, input int ll,
                           input int ss);
        b[i] = 32'(bb);
        l[i] = 32'(ll);
        s[i] = 32'(ss);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = '0;
        ready = '1;
        for (int i = 0; i < N; i++) set_req(i, 0, 0, 0);
        step();
        step();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_gstart", 32'(gen_start), 32'd0);
        chk("rst_gbase", gen_base, 32'd0);
        chk("rst_greset", 32'(gen_rst), 32'd1);
        rst = 1'b0;
        step();
        chk("rel_greset", 32'(gen_rst), 32'd0);
        chk("idle_grant", 32'(grant), 32'd0);

        // 1: single run with stride 2
        q0.delete(); q1.delete(); vhi1 = 0;
        set_req(0, 0, 10, 2);
        start = 2'b01;
        step();
        chk("t1_grant", 32'(grant), 32'd1);
        chk("t1_gstart", 32'(gen_start), 32'd1);
        chk("t1_glimit", gen_limit, 32'd10);
        chk("t1_gstep", gen_step, 32'd2);
        start = 2'b00;
        wait_done("t1_done", 0, 40, n);
        step();
        chk("t1_pulse", 32'(done), 32'd0);
        chk("t1_rel", 32'(grant), 32'd0);
        chk_seq("t1_seq", 0, '{0, 2, 4, 6, 8});
        chk("t1_v1", 32'(vhi1), 32'd0);

        // 2: both requesting from reset, round robin
        rst = 1'b1;
        start = 2'b11;
        set_req(0, 0, 2, 1);
        set_req(1, 10, 12, 1);
        step();
        step();
        q0.delete(); q1.delete();
        rst = 1'b0;
        step();
        chk("t2_g0", 32'(grant), 32'd1);
        wait_done("t2_d0", 0, 20, n);
        chk("t2_gap0", 32'(grant), 32'd0);
        step();
        chk("t2_g1", 32'(grant), 32'd2);
        wait_done("t2_d1", 1, 20, n);
        chk("t2_gap1", 32'(grant), 32'd0);
        step();
        chk("t2_g0b", 32'(grant), 32'd1);
        start = 2'b00;
        wait_done("t2_d0b", 0, 20, n);
        chk_seq("t2_q0", 0, '{0, 1, 0, 1});
        chk_seq("t2_q1", 1, '{10, 11});

        // 3: backpressure on requester 0
        step();
        q0.delete();
        set_req(0, 0, 4, 1);
        ready = 2'b10;
        start = 2'b01;
        step();
        start = 2'b00;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("t3_gready", 32'(gen_ready), 32'd0);
            chk("t3_data", data, 32'd0);
            chk("t3_valid", 32'(valid), 32'd1);
            step();
        end
        ready = 2'b11;
        wait_done("t3_done", 0, 20, n);
        chk_seq("t3_seq", 0, '{0, 1, 2, 3});

        // 4: empty range
        step();
        q1.delete(); vhi1 = 0;
        set_req(1, 5, 5, 1);
        start = 2'b10;
        step();
        chk("t4_grant", 32'(grant), 32'd2);
        start = 2'b00;
        wait_done("t4_done", 1, 4, n);
        chk("t4_v1", 32'(vhi1), 32'd0);
        chk("t4_q1", 32'(q1.size()), 32'd0);

        // 5: reset in the middle of a run
        step();
        set_req(0, 0, 100, 1);
        start = 2'b01;
        step();
        start = 2'b00;
        repeat (5) step();
        chk("t5_busy", 32'(grant), 32'd1);
        rst = 1'b1;
        step();
        chk("t5_grant", 32'(grant), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_greset", 32'(gen_rst), 32'd1);
        rst = 1'b0;
        step();
        q1.delete();
        set_req(1, 3, 6, 1);
        start = 2'b10;
        step();
        chk("t5_g1", 32'(grant), 32'd2);
        start = 2'b00;
        wait_done("t5_d1", 1, 20, n);
        chk_seq("t5_seq", 1, '{3, 4, 5});

        // 6: params captured at grant
        step();
        q0.delete();
        set_req(0, 20, 23, 1);
        start = 2'b01;
        step();
        b[0] = 32'd50;
        start = 2'b00;
        step();
        chk("t6_gbase", gen_base, 32'd20);
        wait_done("t6_done", 0, 20, n);
        step();
        chk("t6_nogrant", 32'(grant), 32'd0);
        chk_seq("t6_seq", 0, '{20, 21, 22});

        chk("overlap", 32'(overlap), 32'd0);
        chk("stray", 32'(stray), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
